// File: rtl/mac_group_accumulator.sv
// rtl/mac_group_accumulator.sv - saturating group accumulator for the multiply-add result stream
//
// Sums a group of unsigned terms (one per cycle) into a saturating accumulator and
// presents the group result on a held output register under a valid/ready handshake.
//
// Ports:
//   clock       sole clock, rising edge
//   reset       asynchronous, active-low reset
//   in_valid    in_data/in_last carry a term this cycle
//   in_ready    block can accept a term this cycle
//   in_data     unsigned term (IN_W bits)
//   in_last     this term closes the group
//   out_valid   group result held on out_*
//   out_ready   consumer takes the result this cycle
//   out_sum     saturated group sum (ACC_W bits)
//   out_count   number of terms in the group (CNT_W bits)
//   out_sat     saturation occurred in this group
//   out_forced  group closed by the MAX_TERMS limit rather than in_last
module mac_group_accumulator #(
  parameter int IN_W      = 17,
  parameter int ACC_W     = 20,
  parameter int MAX_TERMS = 16,
  parameter int CNT_W     = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             out_sat,
  output logic             out_forced
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [ACC_W-1:0] ACC_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MAX_TERMS);

  state_t           state;
  state_t           state_next;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             sat_sticky;

  logic             accept;
  logic             close;
  logic [ACC_W-1:0] acc_base;
  logic [CNT_W-1:0] cnt_base;
  logic             sticky_base;
  logic [ACC_W:0]   sum_wide;
  logic             beat_sat;
  logic [ACC_W-1:0] sum_clip;
  logic [CNT_W-1:0] cnt_inc;

  assign in_ready = !out_valid;
  assign accept   = in_valid && in_ready;

  // A beat in IDLE starts a fresh group, so the running totals are ignored there
  // even though they are already zero after a close or reset.
  always_comb begin
    acc_base    = '0;
    cnt_base    = '0;
    sticky_base = 1'b0;
    if (state == ACCUM) begin
      acc_base    = acc;
      cnt_base    = cnt;
      sticky_base = sat_sticky;
    end
    // One extra bit catches the carry out; that carry is the saturation event.
    sum_wide = {1'b0, acc_base} + {{(ACC_W + 1 - IN_W){1'b0}}, in_data};
    beat_sat = sum_wide[ACC_W];
    sum_clip = beat_sat ? ACC_MAX : sum_wide[ACC_W-1:0];
    cnt_inc  = cnt_base + CNT_W'(1);
    close    = accept && (in_last || (cnt_inc == CNT_LIMIT));
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, ACCUM: begin
        if (accept) begin
          state_next = close ? HOLD : ACCUM;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      acc        <= '0;
      cnt        <= '0;
      sat_sticky <= 1'b0;
      out_valid  <= 1'b0;
      out_sum    <= '0;
      out_count  <= '0;
      out_sat    <= 1'b0;
      out_forced <= 1'b0;
    end else begin
      if (close) begin
        out_valid  <= 1'b1;
        out_sum    <= sum_clip;
        out_count  <= cnt_inc;
        out_sat    <= sticky_base | beat_sat;
        out_forced <= !in_last;
        acc        <= '0;
        cnt        <= '0;
        sat_sticky <= 1'b0;
      end else if (accept) begin
        acc        <= sum_clip;
        cnt        <= cnt_inc;
        sat_sticky <= sticky_base | beat_sat;
      end
      // accept needs !out_valid, so this never collides with a close.
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mac_group_accumulator.sv
// tb/tb_mac_group_accumulator.sv - self-checking bench for mac_group_accumulator
module tb_mac_group_accumulator;

  localparam int IN_W      = 17;
  localparam int ACC_W     = 20;
  localparam int MAX_TERMS = 16;
  localparam int CNT_W     = 5;
  localparam int ACC_MAX   = (1 << ACC_W) - 1;

  logic             clock;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic [CNT_W-1:0] out_count;
  logic             out_sat;
  logic             out_forced;

  mac_group_accumulator #(
    .IN_W(IN_W), .ACC_W(ACC_W), .MAX_TERMS(MAX_TERMS), .CNT_W(CNT_W)
  ) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_count(out_count), .out_sat(out_sat), .out_forced(out_forced)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int sum;
    int cnt;
    bit sat;
    bit forced;
  } res_t;

  res_t exp_q[$];
  int   grp_sum;
  int   grp_cnt;
  bit   grp_sat;
  bit   last_accepted;
  int   last_sum;
  int   last_count;
  int   last_sat;
  int   last_forced;
  int   n_checks;
  int   n_fail;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    grp_sum = 0;
    grp_cnt = 0;
    grp_sat = 0;
  endtask

  task automatic model_beat(input int d, input bit l);
    res_t r;
    grp_sum = grp_sum + d;
    if (grp_sum > ACC_MAX) begin
      grp_sum = ACC_MAX;
      grp_sat = 1;
    end
    grp_cnt++;
    if (l || grp_cnt == MAX_TERMS) begin
      r.sum    = grp_sum;
      r.cnt    = grp_cnt;
      r.sat    = grp_sat;
      r.forced = !l;
      exp_q.push_back(r);
      grp_sum = 0;
      grp_cnt = 0;
      grp_sat = 0;
    end
  endtask

  // Called at the falling edge: compares the DUT against the model, then advances
  // the model by whatever handshakes the coming rising edge will perform.
  task automatic monitor();
    bit mdl_valid;
    mdl_valid = (exp_q.size() != 0);
    check("in_ready", 32'(in_ready), 32'(!mdl_valid));
    check("out_valid", 32'(out_valid), 32'(mdl_valid));
    last_accepted = 0;
    if (mdl_valid) begin
      check("out_sum", 32'(out_sum), 32'(exp_q[0].sum));
      check("out_count", 32'(out_count), 32'(exp_q[0].cnt));
      check("out_sat", 32'(out_sat), 32'(exp_q[0].sat));
      check("out_forced", 32'(out_forced), 32'(exp_q[0].forced));
      if (out_ready) begin
        last_sum    = int'(out_sum);
        last_count  = int'(out_count);
        last_sat    = int'(out_sat);
        last_forced = int'(out_forced);
        void'(exp_q.pop_front());
      end
    end else if (in_valid) begin
      last_accepted = 1;
      model_beat(int'(in_data), in_last);
    end
  endtask

  task automatic step(input logic v, input logic [IN_W-1:0] d, input logic l, input logic r);
    in_valid  = v;
    in_data   = d;
    in_last   = l;
    out_ready = r;
    @(negedge clock);
    monitor();
    @(posedge clock);
    #1;
  endtask

  task automatic beat(input logic [IN_W-1:0] d, input logic l, input logic r);
    bit done;
    done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      step(1'b1, d, l, r);
      done = last_accepted;
    end
    if (!done) check("beat_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b1);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_sum"}, 32'(out_sum), 32'd0);
    check({tag, "_count"}, 32'(out_count), 32'd0);
    check({tag, "_sat"}, 32'(out_sat), 32'd0);
    check({tag, "_forced"}, 32'(out_forced), 32'd0);
    check({tag, "_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    last_sum  = -1;
    last_count = -1;
    last_sat  = -1;
    last_forced = -1;
    model_clear();
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check_reset_state("rst");
    reset = 1'b1;
    @(posedge clock);
    #1;

    // single closing beat
    beat(17'd65280, 1'b1, 1'b0);
    drain(2);
    check("t1_sum", 32'(last_sum), 32'd65280);
    check("t1_count", 32'(last_count), 32'd1);
    check("t1_sat", 32'(last_sat), 32'd0);
    check("t1_forced", 32'(last_forced), 32'd0);

    // four terms, consumer always ready
    beat(17'd100, 1'b0, 1'b1);
    beat(17'd200, 1'b0, 1'b1);
    beat(17'd300, 1'b0, 1'b1);
    beat(17'd400, 1'b1, 1'b1);
    drain(2);
    check("t2_sum", 32'(last_sum), 32'd1000);
    check("t2_count", 32'(last_count), 32'd4);

    // saturation, then the sticky flag must not leak into the next group
    for (int i = 0; i < 9; i++) beat(17'd131071, (i == 8), 1'b1);
    drain(2);
    check("t3_sum", 32'(last_sum), 32'd1048575);
    check("t3_sat", 32'(last_sat), 32'd1);
    check("t3_count", 32'(last_count), 32'd9);
    beat(17'd5, 1'b0, 1'b1);
    beat(17'd5, 1'b1, 1'b1);
    drain(2);
    check("t3b_sum", 32'(last_sum), 32'd10);
    check("t3b_sat", 32'(last_sat), 32'd0);

    // forced close at MAX_TERMS
    for (int i = 0; i < 16; i++) beat(17'd1, 1'b0, 1'b1);
    drain(2);
    check("t4_sum", 32'(last_sum), 32'd16);
    check("t4_count", 32'(last_count), 32'd16);
    check("t4_forced", 32'(last_forced), 32'd1);
    beat(17'd7, 1'b1, 1'b1);
    drain(2);
    check("t4b_sum", 32'(last_sum), 32'd7);
    check("t4b_count", 32'(last_count), 32'd1);
    check("t4b_forced", 32'(last_forced), 32'd0);

    // back-pressure: beats offered during hold must be refused
    beat(17'd3, 1'b0, 1'b0);
    beat(17'd4, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, IN_W'($urandom_range(0, 131071)), 1'b1, 1'b0);
    check("t5_hold_sum", 32'(out_sum), 32'd7);
    check("t5_no_accept", 32'(grp_cnt), 32'd0);
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1);
    check("t5_sum", 32'(last_sum), 32'd7);

    // reset in the middle of a group discards it
    beat(17'd10, 1'b0, 1'b1);
    beat(17'd20, 1'b0, 1'b1);
    beat(17'd30, 1'b0, 1'b1);
    in_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    check_reset_state("t6_rst");
    model_clear();
    #2;
    reset = 1'b1;
    @(posedge clock);
    #1;
    beat(17'd5, 1'b1, 1'b1);
    drain(2);
    check("t6_sum", 32'(last_sum), 32'd5);
    check("t6_count", 32'(last_count), 32'd1);

    // randomized traffic against the reference model
    for (int i = 0; i < 600; i++) begin
      logic [IN_W-1:0] d;
      if ($urandom_range(0, 3) == 0) d = '1;
      else d = IN_W'($urandom_range(0, 131071));
      step($urandom_range(0, 3) != 0, d, $urandom_range(0, 7) == 0, $urandom_range(0, 2) != 0);
    end
    drain(4);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mac_group_accumulator.md
Name: mac_group_accumulator

Overview:
- Downstream consumer of the registered multiply-add stage. Takes its 17-bit result stream, one term per cycle, under valid/ready control.
- Sums a group of terms, such as a dot product of operand vectors, into a wider saturating accumulator.
- Presents the finished group sum on a held output register with a valid/ready handshake.
- The upstream sequencer asserts in_valid and in_last aligned with the multiplier's registered result, i.e. one cycle after it drives the operands.

Parameters:
- IN_W, 17, width of one incoming term. Matches the multiply-add result width.
- ACC_W, 20, accumulator and output sum width. Must be at least IN_W.
- MAX_TERMS, 16, maximum terms per group before a forced close.
- CNT_W, 5, count width. Must be at least clog2(MAX_TERMS+1).

Ports:
- clock  input  1  sole clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_data/in_last carry a term this cycle.
- in_ready  output  1  block can accept a term this cycle.
- in_data  input  IN_W  unsigned term (multiply-add result).
- in_last  input  1  this term closes the group.
- out_valid  output  1  group result held on the out_* ports.
- out_ready  input  1  consumer takes the result this cycle.
- out_sum  output  ACC_W  unsigned group sum, saturated.
- out_count  output  CNT_W  number of terms in the group, 1..MAX_TERMS.
- out_sat  output  1  saturation occurred in this group.
- out_forced  output  1  group closed by the MAX_TERMS limit, not by in_last.

Behaviour:
- Reset (reset low, asynchronous):
  - State becomes IDLE; acc = 0, cnt = 0, sat_sticky = 0.
  - out_valid, out_sum, out_count, out_sat and out_forced all become 0; in_ready becomes 1.
  - A group in progress when reset asserts is discarded, with no partial output.
- Handshake rules:
  - in_ready = !out_valid (combinational from the register).
  - A beat is accepted when in_valid && in_ready. With in_valid low, in_data and in_last are ignored (may be X).
  - The output is taken when out_valid && out_ready.
- States:
  - IDLE: no group open. On an accepted beat: acc = zext(in_data), cnt = 1. If the beat closes the group → CLOSE; otherwise → ACCUM.
  - ACCUM: group open. On an accepted beat: sum = acc + zext(in_data), computed at ACC_W+1 bits; cnt = cnt + 1. With no beat, acc and cnt hold indefinitely (no timeout).
  - CLOSE (closing action; same edge as the closing beat):
    - out_sum = final sum; out_count = final cnt.
    - out_sat = sticky | this beat's saturation; out_forced = !in_last.
    - out_valid = 1; acc, cnt and sticky are cleared; state → HOLD.
  - HOLD: out_* stable while out_valid && !out_ready; in_ready = 0. On out_ready, out_valid = 0 at the next edge and state → IDLE. Exactly one bubble: the earliest next accept is the cycle after the handshake.
- Group-close condition: the accepted beat has in_last = 1, or cnt reaches MAX_TERMS with this beat. If in_last arrives on the MAX_TERMS-th beat, out_forced = 0.
- Saturation: if sum > 2^ACC_W−1, acc = 2^ACC_W−1 and sat_sticky is set. Later terms keep acc at the maximum.
- Latency: out_valid rises on the clock edge that accepts the closing beat, so it is visible in the next cycle.
- out_sum, out_count, out_sat and out_forced keep their last values after the handshake until the next close.
- Throughput: one term per cycle within a group; each group costs one extra bubble cycle.

Test Plan:
1. One beat, in_data = 65280 (255*255+255), in_last = 1 → next cycle out_valid = 1, out_sum = 65280, out_count = 1, out_sat = 0, out_forced = 0.
2. Beats 100, 200, 300, 400 on consecutive cycles, last on 400, out_ready = 1 → out_sum = 1000, out_count = 4. out_valid is high for one cycle; in_ready = 0 for that cycle, then 1.
3. Nine beats of 131071, last on the 9th → out_sum = 1048575, out_sat = 1, out_count = 9. Next group of 5, 5 with last → out_sum = 10, out_sat = 0.
4. Sixteen beats of 1 with in_last = 0, then a 17th beat of 7 with last → first result out_sum = 16, out_count = 16, out_forced = 1; second result out_sum = 7, out_count = 1, out_forced = 0.
5. Group 3 + 4 with last, out_ready held low for 5 cycles while in_valid = 1 → out_sum = 7 stable, in_ready = 0 and no beats accepted. When out_ready = 1, out_valid drops the next cycle and in_ready returns to 1.
6. Beats 10, 20, 30 without last, then reset pulsed low mid-cycle → all outputs 0 immediately. After release, beat 5 with last → out_sum = 5, out_count = 1.
